// File: rtl/mig_pkg.sv
// mig_pkg: shared definitions for the majority-inverter-graph truth-table
// evaluator.
//   - Node-index constants: node 0 is constant 0 and inputs start at node 1.
//   - State enum for the evaluator FSM.
//   - Gate-entry struct. Selectors are sized for the largest legal
//     configuration and zero-extended from the top-level SEL_W.
//   - proj_tt(): truth table of a primary input, at the widest legal width.
package mig_pkg;

  localparam int NODE_CONST0  = 0;
  localparam int NODE_IN_BASE = 1;

  // Widest node index: 1 + 6 inputs + 32 gates = 39 nodes -> 6 bits.
  localparam int SEL_MAX_W = 6;
  // Widest truth table: 2**6 bits.
  localparam int TT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    OUT
  } state_t;

  // neg is {c,b,a}, matching the order of the operand selectors on cfg_sel.
  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel_a;
    logic [SEL_MAX_W-1:0] sel_b;
    logic [SEL_MAX_W-1:0] sel_c;
    logic [2:0]           neg;
  } gate_t;

  // Bit j of input xi's truth table is bit i of the minterm index j.
  function automatic logic [TT_MAX_W-1:0] proj_tt(input int i);
    logic [TT_MAX_W-1:0] r;
    for (int j = 0; j < TT_MAX_W; j++) begin
      r[j] = ((j >> i) & 1) != 0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mig_maj_tt.sv
// mig_maj_tt: bit-parallel three-input majority over W-bit truth tables.
// Each operand can be complemented before the vote.
// Ports:
//   a, b, c  operand truth tables
//   neg      complement flags {c,b,a}
//   y        maj(a', b', c'), computed bitwise
module mig_maj_tt #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [2:0]   neg,
  output logic [W-1:0] y
);

  logic [W-1:0] ax;
  logic [W-1:0] bx;
  logic [W-1:0] cx;

  assign ax = a ^ {W{neg[0]}};
  assign bx = b ^ {W{neg[1]}};
  assign cx = c ^ {W{neg[2]}};
  assign y  = (ax & bx) | (ax & cx) | (bx & cx);

endmodule

// File: rtl/mig_tt_eval.sv
// mig_tt_eval: programmable evaluator for majority-inverter networks.
// A program of up to MAX_GATES majority gates is loaded through the cfg_*
// port. start then evaluates one gate per cycle, and the truth table of
// the selected output node is presented on tt_out with a valid/ready
// handshake.
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   cfg_valid/cfg_ready           gate-slot write handshake (ready only in IDLE)
//   cfg_idx, cfg_sel, cfg_neg     slot index, operand nodes {c,b,a}, complements
//   num_gates, out_sel, out_neg   run parameters, sampled on start
//   start, busy                   begin evaluation / evaluation in progress
//   tt_out, tt_valid, tt_ready    result truth table and its handshake
//   err                           sticky error, cleared by an accepted start
module mig_tt_eval
  import mig_pkg::*;
#(
  parameter  int NUM_IN    = 4,
  parameter  int MAX_GATES = 8,
  localparam int TT_W      = 2 ** NUM_IN,
  localparam int SEL_W     = $clog2(1 + NUM_IN + MAX_GATES),
  localparam int GIDX_W    = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [GIDX_W-1:0]    cfg_idx,
  input  logic [3*SEL_W-1:0]   cfg_sel,
  input  logic [2:0]           cfg_neg,
  input  logic [GIDX_W:0]      num_gates,
  input  logic [SEL_W-1:0]     out_sel,
  input  logic                 out_neg,
  input  logic                 start,
  output logic                 busy,
  output logic [TT_W-1:0]      tt_out,
  output logic                 tt_valid,
  input  logic                 tt_ready,
  output logic                 err
);

  state_t               state;
  state_t               state_next;
  gate_t                prog    [MAX_GATES];
  logic [TT_W-1:0]      gate_tt [MAX_GATES];
  logic [GIDX_W-1:0]    g;
  logic [GIDX_W:0]      num_lat;
  logic [SEL_MAX_W-1:0] osel_lat;
  logic                 oneg_lat;

  logic [NUM_IN*TT_W-1:0]    in_flat;
  logic [MAX_GATES*TT_W-1:0] gate_flat;
  logic [MAX_GATES*TT_W-1:0] gate_fwd;
  gate_t                     cur;
  logic [TT_W:0]             look_a;
  logic [TT_W:0]             look_b;
  logic [TT_W:0]             look_c;
  logic [TT_W:0]             look_o;
  logic                      oneg_cur;
  logic [TT_W-1:0]           maj_y;
  logic cfg_fire, cfg_bad, start_ok, start_bad, last_gate, eval_bad, load_out;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    localparam logic [TT_MAX_W-1:0] PFULL = proj_tt(i);
    assign in_flat[i*TT_W +: TT_W] = PFULL[TT_W-1:0];
  end

  // Returns {bad, value}. Nodes at or beyond the first gate not yet valid
  // (index lim) read as 0 and are flagged.
  function automatic logic [TT_W:0] node_lookup(
    input logic [SEL_MAX_W-1:0]    sel,
    input int                      lim,
    input logic [NUM_IN*TT_W-1:0]  ins,
    input logic [MAX_GATES*TT_W-1:0] gates
  );
    int              s;
    logic [TT_W-1:0] v;
    logic            bad;
    s   = int'(sel);
    v   = '0;
    bad = 1'b0;
    if (s == NODE_CONST0) begin
      v = '0;
    end else if (s < NODE_IN_BASE + NUM_IN) begin
      v = ins[(s - NODE_IN_BASE)*TT_W +: TT_W];
    end else if (s < NODE_IN_BASE + NUM_IN + lim) begin
      v = gates[(s - NODE_IN_BASE - NUM_IN)*TT_W +: TT_W];
    end else begin
      bad = 1'b1;
    end
    return {bad, v};
  endfunction

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == EVAL) || (state == OUT);
  assign cur       = prog[g];

  mig_maj_tt #(.W(TT_W)) u_maj (
    .a   (look_a[TT_W-1:0]),
    .b   (look_b[TT_W-1:0]),
    .c   (look_c[TT_W-1:0]),
    .neg (cur.neg),
    .y   (maj_y)
  );

  // gate_fwd forwards the gate written this cycle so that an output naming
  // the last gate is valid in the same cycle the gate is computed.
  always_comb begin
    gate_flat = '0;
    gate_fwd  = '0;
    for (int k = 0; k < MAX_GATES; k++) begin
      gate_flat[k*TT_W +: TT_W] = gate_tt[k];
      gate_fwd[k*TT_W +: TT_W]  = gate_tt[k];
      if (state == EVAL && int'(g) == k) gate_fwd[k*TT_W +: TT_W] = maj_y;
    end
  end

  always_comb begin
    cfg_fire  = cfg_valid && (state == IDLE);
    cfg_bad   = cfg_fire && (int'(cfg_idx) >= MAX_GATES);
    start_ok  = start && (state == IDLE) && (int'(num_gates) <= MAX_GATES);
    start_bad = start && (state == IDLE) && (int'(num_gates) > MAX_GATES);
    last_gate = (int'(g) == int'(num_lat) - 1);
    look_a    = node_lookup(cur.sel_a, int'(g), in_flat, gate_flat);
    look_b    = node_lookup(cur.sel_b, int'(g), in_flat, gate_flat);
    look_c    = node_lookup(cur.sel_c, int'(g), in_flat, gate_flat);
    eval_bad  = (state == EVAL) && (look_a[TT_W] || look_b[TT_W] || look_c[TT_W]);
    // A zero-gate run loads the result straight from IDLE using the live
    // start-time inputs, since nothing has been latched yet.
    if (state == IDLE) begin
      look_o   = node_lookup(SEL_MAX_W'(out_sel), 0, in_flat, gate_fwd);
      oneg_cur = out_neg;
      load_out = start_ok && (num_gates == '0);
    end else begin
      look_o   = node_lookup(osel_lat, int'(num_lat), in_flat, gate_fwd);
      oneg_cur = oneg_lat;
      load_out = (state == EVAL) && last_gate;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = (num_gates == '0) ? OUT : EVAL;
      EVAL: if (last_gate) state_next = OUT;
      OUT:  if (tt_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_GATES; k++) begin
        prog[k]    <= '0;
        gate_tt[k] <= '0;
      end
      g        <= '0;
      num_lat  <= '0;
      osel_lat <= '0;
      oneg_lat <= 1'b0;
      tt_out   <= '0;
      tt_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (cfg_fire && !cfg_bad) begin
        prog[cfg_idx] <= '{sel_a: SEL_MAX_W'(cfg_sel[SEL_W-1:0]),
                           sel_b: SEL_MAX_W'(cfg_sel[2*SEL_W-1:SEL_W]),
                           sel_c: SEL_MAX_W'(cfg_sel[3*SEL_W-1:2*SEL_W]),
                           neg:   cfg_neg};
      end
      if (start_ok) begin
        num_lat  <= num_gates;
        osel_lat <= SEL_MAX_W'(out_sel);
        oneg_lat <= out_neg;
        g        <= '0;
      end
      if (state == EVAL) begin
        gate_tt[g] <= maj_y;
        if (!last_gate) g <= g + 1'b1;
      end
      if (load_out) begin
        tt_out   <= look_o[TT_W-1:0] ^ {TT_W{oneg_cur}};
        tt_valid <= 1'b1;
      end else if (state == OUT && tt_ready) begin
        tt_valid <= 1'b0;
      end
      // Error sources win over the clear from a start in the same cycle.
      if (cfg_bad || start_bad || eval_bad || (load_out && look_o[TT_W])) begin
        err <= 1'b1;
      end else if (start_ok) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mig_tt_eval.sv
// tb_mig_tt_eval: scoreboard bench for mig_tt_eval with NUM_IN=4, MAX_GATES=8.
// Stimulus pushes the expected result, error flag and due cycle on each start.
// A negedge monitor checks first-valid latency, output stability while
// stalled, and result/error at acceptance.
module tb_mig_tt_eval;

  localparam int NUM_IN    = 4;
  localparam int MAX_GATES = 8;
  localparam int TT_W      = 16;
  localparam int SEL_W     = 4;
  localparam int GIDX_W    = 3;

  typedef struct {
    logic [TT_W-1:0] tt;
    logic            err;
    int              due;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [GIDX_W-1:0]  cfg_idx;
  logic [3*SEL_W-1:0] cfg_sel;
  logic [2:0]         cfg_neg;
  logic [GIDX_W:0]    num_gates;
  logic [SEL_W-1:0]   out_sel;
  logic               out_neg;
  logic               start;
  logic               busy;
  logic [TT_W-1:0]    tt_out;
  logic               tt_valid;
  logic               tt_ready;
  logic               err;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];

  mig_tt_eval #(.NUM_IN(NUM_IN), .MAX_GATES(MAX_GATES)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_sel   (cfg_sel),
    .cfg_neg   (cfg_neg),
    .num_gates (num_gates),
    .out_sel   (out_sel),
    .out_neg   (out_neg),
    .start     (start),
    .busy      (busy),
    .tt_out    (tt_out),
    .tt_valid  (tt_valid),
    .tt_ready  (tt_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  logic            valid_prev = 1'b0;
  logic            ready_prev = 1'b0;
  logic [TT_W-1:0] out_prev   = '0;
  exp_t            cur_exp;

  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      if (tt_valid && !valid_prev) begin
        if (sb.size() == 0) checkOutput("unexpected_valid", 32'(sb.size()), 1);
        else checkOutput("latency", cyc, sb[0].due);
      end
      if (tt_valid && valid_prev && !ready_prev) checkOutput("stall_stable", 32'(tt_out), 32'(out_prev));
      if (tt_valid && tt_ready && sb.size() > 0) begin
        cur_exp = sb.pop_front();
        checkOutput("tt_out", 32'(tt_out), 32'(cur_exp.tt));
        checkOutput("err_at_result", 32'(err), 32'(cur_exp.err));
      end
      valid_prev = tt_valid;
      ready_prev = tt_ready;
      out_prev   = tt_out;
    end
  end

  task automatic writeSlot(input int idx, input int a, input int b, input int c, input logic [2:0] neg);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_idx   = GIDX_W'(idx);
    cfg_sel   = {SEL_W'(c), SEL_W'(b), SEL_W'(a)};
    cfg_neg   = neg;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Issues one start and records the expected result; does not wait.
  task automatic applyStimulus(input int n, input int osel, input logic oneg,
                               input logic [TT_W-1:0] exp_tt, input logic exp_err);
    exp_t e;
    @(posedge clk); #1;
    num_gates = (GIDX_W+1)'(n);
    out_sel   = SEL_W'(osel);
    out_neg   = oneg;
    start     = 1'b1;
    e.tt  = exp_tt;
    e.err = exp_err;
    e.due = cyc + n + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int k;
    k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_neg = '0;
    num_gates = '0; out_sel = '0; out_neg = 1'b0; start = 1'b0; tt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_tt_valid", 32'(tt_valid), 0);
    checkOutput("rst_tt_out", 32'(tt_out), 0);
    checkOutput("rst_err", 32'(err), 0);
    rst = 1'b0;

    // Single gate maj(x0,x1,x2) and complement variants.
    writeSlot(0, 1, 2, 3, 3'b000);
    applyStimulus(1, 5, 1'b0, 16'hE8E8, 1'b0); waitDone(20);
    applyStimulus(1, 5, 1'b1, 16'h1717, 1'b0); waitDone(20);
    writeSlot(0, 1, 2, 0, 3'b100);
    applyStimulus(1, 5, 1'b0, 16'hEEEE, 1'b0); waitDone(20);
    writeSlot(0, 1, 2, 0, 3'b000);
    applyStimulus(1, 5, 1'b0, 16'h8888, 1'b0); waitDone(20);

    // Self/forward reference reads as 0: maj(0,x1,x2) = x1&x2.
    writeSlot(0, 6, 2, 3, 3'b000);
    applyStimulus(1, 5, 1'b0, 16'hC0C0, 1'b1); waitDone(20);

    // Two-gate program with a 5-cycle stall and a write attempt while busy.
    writeSlot(0, 1, 2, 3, 3'b000);
    writeSlot(1, 5, 4, 0, 3'b000);
    tt_ready = 1'b0;
    applyStimulus(2, 6, 1'b0, 16'hE800, 1'b0);
    k = 0;
    while (!tt_valid && k < 20) begin @(posedge clk); #1; k++; end
    checkOutput("valid_seen", 32'(tt_valid), 1);
    cfg_valid = 1'b1; cfg_idx = '0; cfg_sel = '0; cfg_neg = 3'b111;
    checkOutput("cfg_ready_busy", 32'(cfg_ready), 0);
    checkOutput("busy_in_out", 32'(busy), 1);
    repeat (5) begin @(posedge clk); #1; cfg_valid = 1'b0; end
    checkOutput("valid_held", 32'(tt_valid), 1);
    tt_ready = 1'b1;
    waitDone(20);
    applyStimulus(2, 6, 1'b0, 16'hE800, 1'b0); waitDone(20);

    // Zero-gate run: output x3 complemented.
    applyStimulus(0, 4, 1'b1, 16'h00FF, 1'b0); waitDone(20);

    // num_gates beyond MAX_GATES is rejected in IDLE.
    @(posedge clk); #1;
    num_gates = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("bad_n_err", 32'(err), 1);
    checkOutput("bad_n_busy", 32'(busy), 0);
    checkOutput("bad_n_idle", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    checkOutput("bad_n_no_valid", 32'(tt_valid), 0);

    // Asynchronous reset mid-evaluation clears state and program.
    @(posedge clk); #1;
    num_gates = 4'd2; out_sel = 4'd6; out_neg = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("eval_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_tt_valid", 32'(tt_valid), 0);
    checkOutput("arst_tt_out", 32'(tt_out), 0);
    checkOutput("arst_err", 32'(err), 0);
    checkOutput("arst_cfg_ready", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1, 5, 1'b0, 16'h0000, 1'b0); waitDone(20);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
